axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 STARVE_MAX, default 8, maximum consecutive d_cache grants while i_cache waits (range 1-15).
REQ-002 aclk  in  1  single clock; all state changes on rising edge.
REQ-003 aresetn  in  1  synchronous active-low reset.
REQ-004 i_araddr  in  32  i_cache read address.
REQ-005 i_arlen  in  8  i_cache burst length minus one.
REQ-006 i_arsize  in  3  i_cache beat size.
REQ-007 i_arvalid  in  1  i_cache read request.
REQ-008 i_arready  out  1  i_cache request accepted.
REQ-009 i_rvalid  out  1  beat valid for i_cache.
REQ-010 i_rready  in  1  i_cache accepts beat.
REQ-011 d_araddr  in  32  d_cache read address.
REQ-012 d_arlen  in  8  d_cache burst length minus one.
REQ-013 d_arsize  in  3  d_cache beat size.
REQ-014 d_arvalid  in  1  d_cache read request.
REQ-015 d_arready  out  1  d_cache request accepted.
REQ-016 d_rvalid  out  1  beat valid for d_cache.
REQ-017 d_rready  in  1  d_cache accepts beat.
REQ-018 up_rdata  out  32  shared read data to both caches (= rdata).
REQ-019 up_rlast  out  1  shared last-beat flag (= rlast).
REQ-020 arid  out  4  4'd0 for i_cache, 4'd1 for d_cache.
REQ-021 araddr  out  32  AXI read address.
REQ-022 arlen  out  8  AXI burst length.
REQ-023 arsize  out  3  AXI beat size.
REQ-024 arvalid  out  1  AXI address valid.
REQ-025 arready  in  1  AXI address ready.
REQ-026 rdata  in  32  AXI read data.
REQ-027 rlast  in  1  AXI last beat.
REQ-028 rvalid  in  1  AXI read data valid.
REQ-029 rready  out  1  AXI read data ready.

Function
REQ-030 FSM states IDLE, ADDR, DATA; one outstanding read transaction at a time.
REQ-031 IDLE: if any x_arvalid, latch winner's araddr/arlen/arsize and grant; go ADDR next cycle; else stay IDLE.
REQ-032 Priority: d_cache wins when both valid, except i_cache wins when the starve counter equals STARVE_MAX.
REQ-033 ADDR: arvalid=1 with latched fields held stable; on arvalid&arready, pulse granted x_arready for that same cycle only; go DATA.
REQ-034 DATA: x_rvalid = rvalid & (grant==x); rready = granted x_rready; non-granted x_rvalid = 0.
REQ-035 DATA: on rvalid&rready&rlast go IDLE; rlast alone ends the burst, beat count is not compared.
REQ-036 arvalid, i_arready, d_arready are 0 outside ADDR; rready, i_rvalid, d_rvalid are 0 outside DATA.
REQ-037 Latency: request seen at cycle N -> arvalid at N+1; at least one IDLE cycle between consecutive transactions.
REQ-038 Requests are sampled only in IDLE; requester holds x_arvalid until x_arready.

Reset
REQ-039 aresetn=0 at a clock edge: state IDLE, grant i_cache, starve counter 0, latched fields 0, all outputs 0 next cycle, including mid-burst (transaction abandoned, no further beats forwarded).

Configuration
REQ-040 ARB_STARVE_EN defined: 4-bit starve counter increments (saturating at STARVE_MAX) on each d_cache grant while i_arvalid=1, clears on each i_cache grant.
REQ-041 ARB_STARVE_EN undefined: no counter; d_cache strictly wins every simultaneous request.

Verification
REQ-042 Only i_arvalid, araddr 0x1FC00000 arlen 7, arready held 1 -> arid 0, arvalid one cycle, i_arready pulse, 8 beats to i_cache, back to IDLE.
REQ-043 Both valid same cycle -> d_cache granted first (arid 1), i_cache granted after d's rlast plus one IDLE cycle.
REQ-044 ARB_STARVE_EN, STARVE_MAX 2, both held valid -> grant order d, d, i, d, d, i.
REQ-045 rready back-pressure: d_rready low 3 cycles mid-burst -> rready low, no beat lost, d_rvalid tracks rvalid.
REQ-046 aresetn low during beat 3 of an 8-beat burst -> next cycle IDLE, rready 0, both x_rvalid 0, arvalid 0.
REQ-047 arready held 0 for 5 cycles in ADDR -> araddr/arlen/arsize/arid stable, no x_arready pulse until handshake.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter (i_cache / d_cache), one outstanding burst at a time.
// Optional i_cache starvation guard: define ARB_STARVE_EN.

module axi_rd_arbiter #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [31:0] up_rdata,
    output logic        up_rlast,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;   // 1 = d_cache owns the transaction
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        pick_d;
    logic        sel_rready;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be within 1..15");
    end

`ifdef ARB_STARVE_EN
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;

    // i_cache takes the slot once d_cache has won SMAX times in a row over it
    assign pick_d = d_arvalid && !(i_arvalid && (starve_q == SMAX));

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && (i_arvalid || d_arvalid)) begin
            if (!pick_d)
                starve_d = '0;
            else if (i_arvalid && (starve_q < SMAX))
                starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign pick_d = d_arvalid;
`endif

    assign sel_rready = grant_q ? d_rready : i_rready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        case (state_q)
            IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    grant_d  = pick_d;
                    araddr_d = pick_d ? d_araddr : i_araddr;
                    arlen_d  = pick_d ? d_arlen  : i_arlen;
                    arsize_d = pick_d ? d_arsize : i_arsize;
                    state_d  = ADDR;
                end
            end
            ADDR: if (arready) state_d = DATA;
            // rlast alone closes the burst; beats are not counted against arlen
            DATA: if (rvalid && sel_rready && rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arvalid   = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        rready    = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        up_rdata  = '0;
        up_rlast  = 1'b0;
        case (state_q)
            ADDR: begin
                arvalid   = 1'b1;
                i_arready = arready && !grant_q;
                d_arready = arready &&  grant_q;
            end
            DATA: begin
                rready   = sel_rready;
                i_rvalid = rvalid && !grant_q;
                d_rvalid = rvalid &&  grant_q;
                up_rdata = rdata;
                up_rlast = rlast;
            end
            default: ;
        endcase
    end

    assign arid   = {3'b000, grant_q};
    assign araddr = araddr_q;
    assign arlen  = arlen_q;
    assign arsize = arsize_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: requesters, AXI slave, transaction-level grant model.
// Build with ARB_STARVE_EN defined to exercise the starvation guard.

module tb_axi_rd_arbiter;
    localparam int SMAX = 2;
`ifdef ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        aclk, aresetn;
    logic [31:0] i_araddr, d_araddr, araddr, rdata, up_rdata;
    logic [7:0]  i_arlen, d_arlen, arlen;
    logic [2:0]  i_arsize, d_arsize, arsize;
    logic        i_arvalid, i_arready, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rvalid, d_rready;
    logic        up_rlast, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  arid;

    axi_rd_arbiter #(.STARVE_MAX(SMAX)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .up_rdata(up_rdata), .up_rlast(up_rlast), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } req_t;
    typedef struct { logic id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ar_t;
    typedef struct { logic id; logic [31:0] data; logic last; } beat_t;
    typedef struct { logic id; int beats; } burst_t;

    req_t   iq[$], dq[$];
    ar_t    exp_ar[$];
    beat_t  exp_r[$];
    burst_t sl_q[$];
    logic   grant_log[$];

    int   n_checks = 0, n_pass = 0;
    int   ar_pct = 100, rv_pct = 100, rr_pct = 100, ar_low = 0, drr_low = 0;
    int   mcnt = 0, beats_seen = 0;
    logic sl_active = 1'b0, sl_owner = 1'b0, last_prev = 1'b0;
    int   sl_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit busy();
        return iq.size() != 0 || dq.size() != 0 || exp_ar.size() != 0 || exp_r.size() != 0
            || sl_q.size() != 0 || sl_active;
    endfunction

    task automatic add_req(input logic who, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        req_t r;
        r.addr = a; r.len = l; r.size = s;
        if (who) dq.push_back(r);
        else     iq.push_back(r);
    endtask

    task automatic add_rand(input logic who);
        add_req(who, $urandom, 8'($urandom_range(7)), 3'($urandom_range(2)));
    endtask

    // Reference model: with every queued request held valid, replay the grant rules
    // transaction by transaction to get the expected AR order and burst sizes.
    task automatic launch();
        int a = 0, b = 0;
        bit take_d;
        ar_t e;
        burst_t bu;
        beats_seen = 0;
        while (a < iq.size() || b < dq.size()) begin
            if (a < iq.size() && b < dq.size()) take_d = !(STARVE_EN && mcnt == SMAX);
            else                                take_d = (b < dq.size());
            if (take_d) begin
                e.id = 1'b1; e.addr = dq[b].addr; e.len = dq[b].len; e.size = dq[b].size;
                if (STARVE_EN && a < iq.size() && mcnt < SMAX) mcnt++;
                b++;
            end else begin
                e.id = 1'b0; e.addr = iq[a].addr; e.len = iq[a].len; e.size = iq[a].size;
                mcnt = 0;
                a++;
            end
            exp_ar.push_back(e);
            bu.id = e.id; bu.beats = int'(e.len) + 1;
            sl_q.push_back(bu);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (busy() && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        chk("drain_timeout", 64'(busy()), 64'd0);
        repeat (2) @(negedge aclk);
        #1;
    endtask

    task automatic zero_outputs_check(input string tag);
        chk({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        chk({tag, "_x_arready"}, 64'({i_arready, d_arready}), 64'd0);
        chk({tag, "_rready"}, 64'(rready), 64'd0);
        chk({tag, "_x_rvalid"}, 64'({i_rvalid, d_rvalid}), 64'd0);
        chk({tag, "_ar_fields"}, {araddr, 17'd0, arlen, arsize, arid, 1'b0}, 64'd0);
        chk({tag, "_up"}, 64'({up_rlast, up_rdata}), 64'd0);
    endtask

    // Requesters and AXI slave: sample at negedge, drive just after posedge.
    initial begin : driver
        logic hi, hd, ar, rb, rs;
        burst_t bu;
        beat_t bt;
        i_arvalid = 0; d_arvalid = 0; i_araddr = 0; d_araddr = 0; i_arlen = 0; d_arlen = 0;
        i_arsize = 0; d_arsize = 0; i_rready = 0; d_rready = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0;
        forever begin
            @(negedge aclk);
            hi = i_arvalid & i_arready; hd = d_arvalid & d_arready;
            ar = arvalid & arready;     rb = rvalid & rready; rs = aresetn;
            @(posedge aclk);
            #1;
            if (!rs) begin
                iq.delete(); dq.delete(); exp_ar.delete(); exp_r.delete(); sl_q.delete();
                sl_active = 0; i_arvalid = 0; d_arvalid = 0; arready = 0;
            end else begin
                if (hi && iq.size() > 0) void'(iq.pop_front());
                if (hd && dq.size() > 0) void'(dq.pop_front());
                if (ar && sl_q.size() > 0) begin
                    bu = sl_q.pop_front();
                    sl_active = 1; sl_owner = bu.id; sl_left = bu.beats; rvalid = 0;
                end
                if (rb && sl_active) begin
                    rvalid = 0;
                    sl_left--;
                    if (sl_left == 0) sl_active = 0;
                end
                if (!sl_active) rvalid = 0;
                else if (!rvalid && int'($urandom_range(99)) < rv_pct) begin
                    rdata = $urandom; rlast = (sl_left == 1); rvalid = 1;
                    bt.id = sl_owner; bt.data = rdata; bt.last = rlast;
                    exp_r.push_back(bt);
                end
                i_arvalid = iq.size() > 0;
                if (i_arvalid) begin i_araddr = iq[0].addr; i_arlen = iq[0].len; i_arsize = iq[0].size; end
                d_arvalid = dq.size() > 0;
                if (d_arvalid) begin d_araddr = dq[0].addr; d_arlen = dq[0].len; d_arsize = dq[0].size; end
                arready = (ar_low > 0) ? 1'b0 : (int'($urandom_range(99)) < ar_pct);
                if (ar_low > 0) ar_low--;
                i_rready = int'($urandom_range(99)) < rr_pct;
                d_rready = (drr_low > 0) ? 1'b0 : (int'($urandom_range(99)) < rr_pct);
                if (drr_low > 0) drr_low--;
            end
        end
    end

    initial begin : monitor
        ar_t e;
        beat_t b;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                last_prev = 0;
                continue;
            end
            if (arvalid) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 64'(arvalid), 64'd0);
                else begin
                    e = exp_ar[0];
                    chk("arid", 64'(arid), 64'(e.id));
                    chk("araddr", 64'(araddr), 64'(e.addr));
                    chk("arlen", 64'(arlen), 64'(e.len));
                    chk("arsize", 64'(arsize), 64'(e.size));
                    chk("i_arready", 64'(i_arready), 64'(arready && !e.id));
                    chk("d_arready", 64'(d_arready), 64'(arready && e.id));
                    if (arready) begin
                        void'(exp_ar.pop_front());
                        grant_log.push_back(e.id);
                    end
                end
            end else chk("x_arready_no_ar", 64'({i_arready, d_arready}), 64'd0);
            if (sl_active || last_prev) chk("ar_gap", 64'(arvalid), 64'd0);
            if (sl_active) begin
                chk("rready", 64'(rready), 64'(sl_owner ? d_rready : i_rready));
                chk("i_rvalid", 64'(i_rvalid), 64'(rvalid && !sl_owner));
                chk("d_rvalid", 64'(d_rvalid), 64'(rvalid && sl_owner));
            end else chk("r_no_data", 64'({rready, i_rvalid, d_rvalid}), 64'd0);
            last_prev = 0;
            if ((i_rvalid && i_rready) || (d_rvalid && d_rready)) begin
                if (exp_r.size() == 0) chk("r_unexpected", 64'({i_rvalid, d_rvalid}), 64'd0);
                else begin
                    b = exp_r.pop_front();
                    chk("r_owner", 64'(d_rvalid), 64'(b.id));
                    chk("rdata", 64'(up_rdata), 64'(b.data));
                    chk("rlast", 64'(up_rlast), 64'(b.last));
                    beats_seen++;
                    last_prev = rvalid && rready && rlast;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : main
        logic [5:0] order;
        int k;
        aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        zero_outputs_check("reset");
        @(posedge aclk); #1 aresetn = 1;
        @(negedge aclk); #1;

        // single i_cache burst, arready held high, first-request latency
        add_req(1'b0, 32'h1FC0_0000, 8'd7, 3'd2);
        launch();
        @(negedge aclk);
        chk("lat_idle_arvalid", 64'(arvalid), 64'd0);
        @(negedge aclk);
        chk("lat_arvalid", 64'(arvalid), 64'd1);
        chk("lat_i_arready", 64'(i_arready), 64'd1);
        @(negedge aclk);
        chk("ar_one_cycle", 64'(arvalid), 64'd0);
        drain();
        chk("t1_beats", 64'(beats_seen), 64'd8);

        // simultaneous requests: d first, i after an IDLE gap
        add_rand(1'b0); add_rand(1'b1);
        launch(); drain();

        // long backlog on both sides: grant order
        grant_log.delete();
        repeat (3) add_rand(1'b0);
        repeat (5) add_rand(1'b1);
        launch(); drain();
        order = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) order = {order[4:0], grant_log[i]};
        chk("grant_order", 64'(order), STARVE_EN ? 64'b110110 : 64'b111110);

        // d_rready back-pressure mid-burst
        add_req(1'b1, 32'hA000_0040, 8'd7, 3'd2);
        launch();
        k = 0;
        while (beats_seen < 2 && k < 200) begin @(negedge aclk); k++; end
        #1 drr_low = 3;
        drain();
        chk("bp_beats", 64'(beats_seen), 64'd8);

        // arready held low while the address is presented
        ar_low = 6;
        add_req(1'b0, 32'h0000_1230, 8'd3, 3'd1);
        launch(); drain();
        chk("ar_stall_beats", 64'(beats_seen), 64'd4);

        // reset in the middle of beat 3
        add_req(1'b1, 32'hB000_0000, 8'd7, 3'd2);
        launch();
        k = 0;
        while (k < 200) begin
            @(posedge aclk); #1;
            if (beats_seen >= 2) break;
            k++;
        end
        aresetn = 0;
        @(posedge aclk);
        @(negedge aclk);
        zero_outputs_check("midburst_rst");
        @(posedge aclk); #1 aresetn = 1;
        mcnt = 0;
        repeat (3) @(negedge aclk);
        chk("rst_no_more_beats", 64'(beats_seen), 64'd2);
        chk("rst_x_rvalid", 64'({i_rvalid, d_rvalid, rready}), 64'd0);
        drain();

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int ni, nd;
            ar_pct = $urandom_range(30, 100);
            rv_pct = $urandom_range(30, 100);
            rr_pct = $urandom_range(30, 100);
            ni = $urandom_range(3);
            nd = $urandom_range(3);
            if (ni == 0 && nd == 0) ni = 1;
            for (int i = 0; i < ni; i++) add_rand(1'b0);
            for (int i = 0; i < nd; i++) add_rand(1'b1);
            launch(); drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
